product_bcd_converter: RTL
==========================

Name: product_bcd_converter

Overview:
- Downstream stage of the signed 8x8 serial multiplier controller.
- Watches the controller's done level. On its rising edge, captures the 16-bit two's-complement product and converts its magnitude to packed BCD with a sequential double-dabble algorithm (one shift per clock).
- Outputs a sign flag plus five BCD digits for the seven-segment display driver.

Parameters:
- WIDTH, 16, product width in bits; only 16 is supported.
- DIGITS, 5, number of BCD digits produced; must be 5 when WIDTH=16.

Ports:
- clk_out_i  input  1  system clock, same divided clock as the multiplier controller
- rst_i  input  1  asynchronous, active-high reset
- done_i  input  1  multiplier done level; conversion triggers on its 0->1 transition
- product_i  input  WIDTH  signed product; stable while done_i is high
- sign_o  output  1  1 = captured product was negative
- bcd_o  output  4*DIGITS  packed BCD magnitude; [3:0] = ones digit, [19:16] = ten-thousands digit
- valid_o  output  1  bcd_o/sign_o hold a completed conversion
- busy_o  output  1  conversion in progress

Behaviour:
- Reset (async, active-high), all cleared:
  - state = IDLE, done_q = 0
  - sign_o = 0, bcd_o = 0, valid_o = 0, busy_o = 0
  - internal shift register and counter = 0
- Edge detect:
  - done_q is done_i registered each clock.
  - A trigger occurs when done_i=1 and done_q=0.
  - If done_i is already high at the first clock after reset release, that counts as a trigger.
- States:
  - IDLE: on trigger, load magnitude = product_i[15] ? (~product_i + 1) : product_i, taken as 16-bit unsigned (0x8000 -> 32768). Latch the sign internally, clear the BCD accumulator, count = 0, clear valid_o, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD digit >= 5, then shift the {bcd, magnitude} register left by one; count++. After the 16th shift (count reaches 15 and increments), go to DONE.
  - DONE: one cycle. Transfer the accumulator to bcd_o and the sign to sign_o, set valid_o = 1, return to IDLE.
- busy_o = 1 exactly while the state is SHIFT or DONE.
- Latency: valid_o rises on the 18th rising edge counting the trigger edge as 1 (1 load + 16 shift + 1 done).
- valid_o, bcd_o and sign_o hold until the next trigger or reset. valid_o drops on the trigger edge; bcd_o/sign_o keep their old values until the new result lands.
- Triggers while busy are ignored, not queued. done_q still tracks done_i, so a level held high produces no second trigger.
- A zero product gives sign_o = 0, never "-0".
- Reset mid-conversion aborts immediately to the reset values; no partial result is ever presented.
- product_i is sampled only on the trigger edge; later changes have no effect on the conversion.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in DONE, each leading-zero digit from the most significant digit down to (but excluding) the ones digit is replaced by 4'hF, the display driver's blank code. The ones digit is never blanked. Example: 42 -> bcd_o = 0xFFF42.
- Undefined: plain BCD with leading zeros (42 -> 0x00042).
- Either way: latency unchanged, sign_o unaffected.

Test Plan:
- Reset, then product_i = 0x4000 (-128 x -128 = 16384), raise done_i -> after 18 edges: valid_o = 1, sign_o = 0, bcd_o = 0x16384; busy_o high for exactly 17 cycles.
- product_i = 0xC080 (-16256) -> sign_o = 1, bcd_o = 0x16256; with LEADING_ZERO_BLANK_EN, product_i = 0x002A -> bcd_o = 0xFFF42.
- product_i = 0x0000 -> sign_o = 0, bcd_o = 0x00000 (0xFFFF0 when blanking is enabled); product_i = 0x8000 -> sign_o = 1, bcd_o = 0x32768.
- Hold done_i high for 100 cycles, and toggle done_i low/high at cycle 5 of a conversion -> exactly one conversion; the mid-conversion edge is ignored; result matches the first capture.
- Assert rst_i asynchronously mid-clock at SHIFT cycle 8 -> all outputs 0 immediately. Release, drop done_i, raise it with 0x1234 (4660) -> bcd_o = 0x04660, valid_o after 18 edges.
- Back-to-back: convert 0x0064 (100), then drop done_i, change product_i to 0xFF9C (-100), raise done_i -> valid_o falls on the trigger edge, then returns with sign_o = 1, bcd_o = 0x00100.

Source files
------------

// File: rtl/product_bcd_converter.sv
// Captures the signed product on the rising edge of done_i and converts its magnitude to packed BCD (one double-dabble shift per clock).
// Optional: define LEADING_ZERO_BLANK_EN to replace leading-zero digits with the blank code 4'hF.
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_out_i,
    input  logic                  rst_i,
    input  logic                  done_i,
    input  logic [WIDTH-1:0]      product_i,
    output logic                  sign_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state, state_nx;
    logic                done_q;
    logic                sign_q, sign_q_nx;
    logic [4*DIGITS-1:0] acc, acc_nx, acc_adj, acc_out;
    logic [WIDTH-1:0]    mag, mag_nx;
    logic [CW-1:0]       count, count_nx;
    logic                sign_nx, valid_nx;
    logic [4*DIGITS-1:0] bcd_nx;
    logic                trigger;

    assign trigger = done_i & ~done_q;
    assign busy_o  = (state != IDLE);

    // Add-3 correction applied ahead of every shift.
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zeros from the top digit down until the first non-zero; ones digit always shown.
    always_comb begin
        logic lead;
        acc_out = acc;
        lead    = 1'b1;
        for (int unsigned i = 0; i < DIGITS - 1; i++) begin
            if (lead && (acc[4*(DIGITS-1-i) +: 4] == 4'd0))
                acc_out[4*(DIGITS-1-i) +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end
`else
    always_comb begin
        acc_out = acc;
    end
`endif

    always_comb begin
        state_nx  = state;
        sign_q_nx = sign_q;
        acc_nx    = acc;
        mag_nx    = mag;
        count_nx  = count;
        sign_nx   = sign_o;
        bcd_nx    = bcd_o;
        valid_nx  = valid_o;
        case (state)
            IDLE: begin
                if (trigger) begin
                    mag_nx    = product_i[WIDTH-1] ? (~product_i + 1'b1) : product_i;
                    sign_q_nx = product_i[WIDTH-1];
                    acc_nx    = '0;
                    count_nx  = '0;
                    valid_nx  = 1'b0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                {acc_nx, mag_nx} = {acc_adj, mag} << 1;
                count_nx = count + 1'b1;
                if (count == CW'(WIDTH - 1))
                    state_nx = DONE;
            end
            DONE: begin
                bcd_nx   = acc_out;
                sign_nx  = sign_q;
                valid_nx = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_out_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            acc     <= '0;
            mag     <= '0;
            count   <= '0;
            sign_o  <= 1'b0;
            bcd_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_nx;
            done_q  <= done_i;
            sign_q  <= sign_q_nx;
            acc     <= acc_nx;
            mag     <= mag_nx;
            count   <= count_nx;
            sign_o  <= sign_nx;
            bcd_o   <= bcd_nx;
            valid_o <= valid_nx;
        end
    end

endmodule
